// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, port count.
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane insert (sub-word stores) and lane extract with
// sign/zero extension (sub-word loads) on a little-endian 32-bit word.
module dmem_lane_merge
    import dmem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [31:0] shifted;

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Halfword accesses are already known to be aligned, so offset*8 is 0 or 16.
    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: extracted = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: extracted = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: extracted = word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter and sub-word access sequencer (RMW for sub-word stores).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_signed,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_signed,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_rd_add,
    output logic [31:0] mem_wr_add,
    output logic [31:0] mem_wr_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic        port_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sgn_q;
    logic        err_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic                 any_req;
    logic                 win;
    logic                 grant;
    logic [NUM_PORTS-1:0] gnt_vec;
    logic                 sel_we;
    logic                 sel_sgn;
    logic [1:0]           sel_size;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic                 sel_err;
    logic [31:0]          merged;
    logic [31:0]          extracted;

    assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win = ~p0_req;
`else
    logic last_q;
    assign win = (p0_req & p1_req) ? ~last_q : p1_req;
`endif

    // Grant is combinational in IDLE but forced low while reset is held.
    assign grant   = (state == IDLE) && any_req && !rst;
    assign gnt_vec = {grant & win, grant & ~win};
    assign p0_gnt  = gnt_vec[0];
    assign p1_gnt  = gnt_vec[1];

    assign sel_we    = win ? p1_we     : p0_we;
    assign sel_sgn   = win ? p1_signed : p0_signed;
    assign sel_size  = win ? p1_size   : p0_size;
    assign sel_addr  = win ? p1_addr   : p0_addr;
    assign sel_wdata = win ? p1_wdata  : p0_wdata;

    assign sel_err = (sel_size == 2'b11)
                  || (sel_size == SZ_HALF && sel_addr[0])
                  || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00)
                  || (sel_addr >= 32'(MEM_BYTES));

    // The RD cycle extracts straight from the memory bus; WR merges into the buffered word.
    dmem_lane_merge u_lane_merge (
        .word      ((state == WR) ? buf_q : mem_rdata),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .wdata     (wdata_q),
        .sign_ext  (sgn_q),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            port_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            sgn_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        port_q  <= win;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        size_q  <= sel_size;
                        we_q    <= sel_we;
                        sgn_q   <= sel_sgn;
                        err_q   <= sel_err;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_q  <= win;
`endif
                        if (sel_err) begin
                            state <= RESP;
                            if (win) rdata1_q <= '0;
                            else     rdata0_q <= '0;
                        end else if (sel_we && sel_size == SZ_WORD) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    buf_q <= mem_rdata;
                    if (we_q) begin
                        state <= WR;
                    end else begin
                        state <= RESP;
                        if (port_q) rdata1_q <= extracted;
                        else        rdata0_q <= extracted;
                    end
                end
                WR:      state <= IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read    = (state == RD);
    assign mem_write   = (state == WR);
    assign mem_rd_add  = mem_read  ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wr_add  = mem_write ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wr_data = mem_write ? merged : '0;

    assign p0_done  = (state == WR || state == RESP) && !port_q;
    assign p1_done  = (state == WR || state == RESP) &&  port_q;
    assign p0_err   = (state == RESP) && err_q && !port_q;
    assign p1_err   = (state == RESP) && err_q &&  port_q;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural 128-byte memory.
// Contention expectations follow DMEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p0_signed = 0;
    logic [1:0]  p0_size = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0;
    logic        p1_req = 0, p1_we = 0, p1_signed = 0;
    logic [1:0]  p1_size = 0;
    logic [31:0] p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_rd_add, mem_wr_add, mem_wr_data, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:31];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        chk_rdata;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    dmem_arbiter #(.MEM_BYTES(128)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_signed(p0_signed),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_signed(p1_signed),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_rd_add(mem_rd_add), .mem_wr_add(mem_wr_add), .mem_wr_data(mem_wr_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory commits on the edge that ends the WR cycle; reads are asynchronous.
    always @(posedge clk) begin
        if (mem_write) mem[mem_wr_add[6:2]] <= mem_wr_data;
    end
    assign mem_rdata = mem[mem_rd_add[6:2]];

    function automatic vec_t mk(input logic port, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input logic chk_rdata);
        vec_t v;
        v.port = port; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.chk_rdata = chk_rdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (item %0d) actual=0x%08h required=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drivePort(input logic port, input logic req, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_size = size; p1_signed = sgn; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_size = size; p0_signed = sgn; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bit          got;
        bit          strobe;
        int          lat;
        logic        er;
        logic [31:0] rd;
        er = 1'b0; rd = '0; lat = 0;
        @(negedge clk);
        drivePort(v.port, 1'b1, v.we, v.size, v.sgn, v.addr, v.wdata);
        #1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (v.port ? p1_gnt : p0_gnt) begin
                got = 1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!got) begin
            checkOutput("gnt_timeout", idx, 32'd0, 32'd1);
            drivePort(v.port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
            return;
        end
        strobe = mem_read | mem_write;
        @(posedge clk); #1;
        drivePort(v.port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            strobe = strobe | mem_read | mem_write;
            if (v.port ? p1_done : p0_done) begin
                got = 1;
                lat = k;
                er  = v.port ? p1_err : p0_err;
                rd  = v.port ? p1_rdata : p0_rdata;
                break;
            end
        end
        if (!got) begin
            checkOutput("done_timeout", idx, 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", idx, lat, v.exp_lat);
        checkOutput("err", idx, {31'd0, er}, {31'd0, v.exp_err});
        if (v.chk_rdata) checkOutput("rdata", idx, rd, v.exp_rdata);
        if (v.exp_err) checkOutput("err_no_strobe", idx, {31'd0, strobe}, 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_strobes"}, 0,
                    {26'd0, p0_done, p1_done, p0_err, p1_err, mem_read, mem_write}, 32'd0);
        checkOutput({name, "_p0_rdata"}, 0, p0_rdata, 32'd0);
        checkOutput({name, "_p1_rdata"}, 0, p1_rdata, 32'd0);
        checkOutput({name, "_mem_bus"}, 0, mem_rd_add | mem_wr_add | mem_wr_data, 32'd0);
    endtask

    initial begin
        int   order [8];
        int   when  [8];
        int   ng;
        int   cyc;
        bit   seen_bad;
        bit   got;
        vec_t pre;

        vecs[0]  = mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 0);
        vecs[1]  = mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1);
        vecs[2]  = mk(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        0, 1, 0);
        vecs[3]  = mk(1, 1, 2'b00, 0, 32'h22, 32'h000000AA, 32'h0,        0, 2, 0);
        vecs[4]  = mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h11AA3344, 0, 2, 1);
        vecs[5]  = mk(0, 0, 2'b00, 1, 32'h22, 32'h0,        32'hFFFFFFAA, 0, 2, 1);
        vecs[6]  = mk(1, 0, 2'b00, 0, 32'h22, 32'h0,        32'h000000AA, 0, 2, 1);
        vecs[7]  = mk(1, 0, 2'b00, 1, 32'h23, 32'h0,        32'h00000011, 0, 2, 1);
        vecs[8]  = mk(0, 1, 2'b10, 0, 32'h24, 32'h0,        32'h0,        0, 1, 0);
        vecs[9]  = mk(0, 1, 2'b01, 0, 32'h26, 32'h0000BEEF, 32'h0,        0, 2, 0);
        vecs[10] = mk(1, 0, 2'b10, 0, 32'h24, 32'h0,        32'hBEEF0000, 0, 2, 1);
        vecs[11] = mk(0, 0, 2'b01, 1, 32'h26, 32'h0,        32'hFFFFBEEF, 0, 2, 1);
        vecs[12] = mk(1, 0, 2'b01, 0, 32'h24, 32'h0,        32'h00000000, 0, 2, 1);
        vecs[13] = mk(0, 0, 2'b10, 0, 32'h13, 32'h0,        32'h00000000, 1, 1, 1);
        vecs[14] = mk(1, 0, 2'b01, 0, 32'h05, 32'h0,        32'h00000000, 1, 1, 1);
        vecs[15] = mk(0, 0, 2'b11, 0, 32'h00, 32'h0,        32'h00000000, 1, 1, 1);
        vecs[16] = mk(1, 0, 2'b10, 0, 32'h80, 32'h0,        32'h00000000, 1, 1, 1);
        vecs[17] = mk(0, 1, 2'b11, 0, 32'h10, 32'h0,        32'h00000000, 1, 1, 1);
        vecs[18] = mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Abort a byte store during its RD cycle; the target word must survive.
        pre = mk(1, 1, 2'b10, 0, 32'h30, 32'h5555AAAA, 32'h0, 0, 1, 0);
        applyStimulus(pre, 100);
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h00000077);
        #1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (p0_gnt) begin got = 1; break; end
            @(negedge clk); #1;
        end
        checkOutput("rst_gnt_seen", 101, {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        drivePort(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        checkOutput("rst_in_rd", 101, {31'd0, mem_read}, 32'd1);
        #2 rst = 1'b1;
        #1 checkAllZero("async_rst");
        seen_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            seen_bad = seen_bad | mem_write | p0_done | p1_done;
        end
        checkOutput("rst_no_write_done", 102, {31'd0, seen_bad}, 32'd0);
        checkOutput("rst_mem_intact", 102, mem[12], 32'h5555AAAA);

        // Contention right after reset: both ports hold word-load requests.
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        drivePort(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'd0);
        ng = 0;
        for (cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            #1;
            if (p0_gnt || p1_gnt) begin
                order[ng] = p1_gnt ? 1 : 0;
                when[ng]  = cyc;
                ng++;
            end
            @(negedge clk);
        end
        checkOutput("contention_grants", 200, ng, 6);
        for (int i = 0; i < ng; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            checkOutput("contention_order", 200 + i, order[i], 0);
`else
            checkOutput("contention_order", 200 + i, order[i], i % 2);
`endif
            if (i > 0) checkOutput("contention_gap", 200 + i, when[i] - when[i-1], 3);
        end
        @(posedge clk); #1;
        p0_req = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (p0_gnt || p1_gnt) begin got = 1; break; end
        end
        checkOutput("p1_after_p0_drop", 210, {31'd0, got & p1_gnt}, 32'd1);
        @(posedge clk); #1;
        p1_req = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p1_done) begin got = 1; break; end
        end
        checkOutput("p1_contention_done", 211, {31'd0, got}, 32'd1);
        checkOutput("p1_contention_rdata", 211, p1_rdata, 32'hBEEF0000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
